// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encodings
// and the chunk-width helper used to split the carry chain.
package adder_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline slot: adds chunk IDX of the operands with the incoming carry,
// merges it into the running sum and forwards operands to the next slot.
module adder_pipe_stage
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int C     = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_sum,
  input  logic             up_carry,
  input  logic             down_adv,
  output logic             load,
  output logic             valid,
  output logic [WIDTH-1:0] a_fwd,
  output logic [WIDTH-1:0] b_fwd,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  logic [C:0]       chunk_s;
  logic [WIDTH-1:0] sum_next_s;
  logic             overflow_next_s;
  logic             zero_next_s;
  logic             load_s;
  logic             valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             overflow_r;
  logic             zero_r;

  // chunk adder and flag precompute; flags are only meaningful in the last slot
  always_comb begin
    chunk_s    = {1'b0, up_a[IDX*C +: C]} + {1'b0, up_b[IDX*C +: C]} + {{C{1'b0}}, up_carry};
    sum_next_s = up_sum;
    sum_next_s[IDX*C +: C] = chunk_s[C-1:0];
    overflow_next_s = (up_a[WIDTH-1] == up_b[WIDTH-1]) && (sum_next_s[WIDTH-1] != up_a[WIDTH-1]);
    zero_next_s     = ~|sum_next_s;
  end

  // slot takes new data when empty or when its content moves downstream
  always_comb begin
    load_s = !valid_r || down_adv;
  end

  // slot registers; data only captured for real beats so bubbles cost no toggling
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      sum_r      <= {WIDTH{1'b0}};
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
    end else if (load_s) begin
      valid_r <= up_valid;
      if (up_valid) begin
        a_r        <= up_a;
        b_r        <= up_b;
        sum_r      <= sum_next_s;
        carry_r    <= chunk_s[C];
        overflow_r <= overflow_next_s;
        zero_r     <= zero_next_s;
      end
    end
  end

  assign load     = load_s;
  assign valid    = valid_r;
  assign a_fwd    = a_r;
  assign b_fwd    = b_r;
  assign sum      = sum_r;
  assign carry    = carry_r;
  assign overflow = overflow_r;
  assign zero     = zero_r;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined two's-complement adder/subtractor with elastic valid/ready
// handshake; STAGES chunk slots, latency STAGES, one beat per cycle.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int C = chunk_width(WIDTH, STAGES);

  logic             valid_s    [0:STAGES];
  logic             adv_s      [0:STAGES];
  logic [WIDTH-1:0] a_s        [0:STAGES];
  logic [WIDTH-1:0] b_s        [0:STAGES];
  logic [WIDTH-1:0] sum_s      [0:STAGES];
  logic             carry_s    [0:STAGES];
  logic             overflow_s [1:STAGES];
  logic             zero_s     [1:STAGES];
  logic [WIDTH-1:0] b_eff_s;

  // subtraction is A + ~B + 1, the +1 entering as the stage-0 carry
  always_comb begin
    if (sub == OP_SUB) begin
      b_eff_s = ~b;
    end else begin
      b_eff_s = b;
    end
  end

  assign valid_s[0]     = in_valid;
  assign a_s[0]         = a;
  assign b_s[0]         = b_eff_s;
  assign sum_s[0]       = {WIDTH{1'b0}};
  assign carry_s[0]     = sub;
  assign adv_s[STAGES]  = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    adder_pipe_stage #(
      .WIDTH (WIDTH),
      .C     (C),
      .IDX   (i)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (valid_s[i]),
      .up_a     (a_s[i]),
      .up_b     (b_s[i]),
      .up_sum   (sum_s[i]),
      .up_carry (carry_s[i]),
      .down_adv (adv_s[i+1]),
      .load     (adv_s[i]),
      .valid    (valid_s[i+1]),
      .a_fwd    (a_s[i+1]),
      .b_fwd    (b_s[i+1]),
      .sum      (sum_s[i+1]),
      .carry    (carry_s[i+1]),
      .overflow (overflow_s[i+1]),
      .zero     (zero_s[i+1])
    );
  end

  assign in_ready  = adv_s[0];
  assign out_valid = valid_s[STAGES];
  assign sum       = sum_s[STAGES];
  assign carry_out = carry_s[STAGES];
  assign overflow  = overflow_s[STAGES];
  assign zero      = zero_s[STAGES];

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed table, random streaming,
// backpressure and mid-stream reset on a 32/4 and an 8/1 instance.
module tb_adder_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  typedef struct {
    logic [34:0] v;
    int          t;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        iv32, ir32, s32, ov32, or32, c32, o32, z32;
  logic [31:0] a32, b32, sum32;
  logic        iv8, ir8, s8, ov8, or8, c8, o8, z8;
  logic [7:0]  a8, b8, sum8;

  exp_t        exp_q[$];
  int          cyc, passed, total, n_emit;
  bit          lat_chk;
  logic        last_ir, last_ov;
  logic [34:0] last_got;

  adder_pipe #(.WIDTH(32), .STAGES(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .sub(s32),
    .out_valid(ov32), .out_ready(or32), .sum(sum32), .carry_out(c32), .overflow(o32), .zero(z32));

  adder_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(s8),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .carry_out(c8), .overflow(o8), .zero(z8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed/unsigned arithmetic on w-bit values.
  function automatic logic [34:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    longint one, mask, ua, ub, sa, sb, r, sr, rm;
    logic c, o;
    one  = 64'sd1;
    mask = (one << w) - one;
    ua = longint'(x) & mask;
    ub = longint'(y) & mask;
    sa = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
    sb = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
    if (!s) begin
      r  = ua + ub;
      c  = (r > mask);
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    o  = (sr > (one << (w - 1)) - one) || (sr < -(one << (w - 1)));
    rm = r & mask;
    return {rm[31:0], c, o, (rm == 64'sd0)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: event not expected / bound expired (cycle %0d)", name, cyc);
  endtask

  // One clock cycle on the selected DUT: drive, sample, score, advance.
  task automatic cycle(input bit sel8, input logic r, input logic iv, input logic [31:0] x,
                       input logic [31:0] y, input logic s, input logic ordy);
    exp_t e;
    logic vld, rdy;
    logic [34:0] got;
    rst = r;
    if (sel8) begin
      iv8 = iv; a8 = x[7:0]; b8 = y[7:0]; s8 = s; or8 = ordy;
      iv32 = 1'b0; or32 = 1'b1;
    end else begin
      iv32 = iv; a32 = x; b32 = y; s32 = s; or32 = ordy;
      iv8 = 1'b0; or8 = 1'b1;
    end
    #1;
    vld = sel8 ? ov8 : ov32;
    rdy = sel8 ? ir8 : ir32;
    got = sel8 ? {24'h0, sum8, c8, o8, z8} : {sum32, c32, o32, z32};
    last_ir = rdy; last_ov = vld; last_got = got;
    if (!r) begin
      if (vld && ordy) begin
        n_emit++;
        if (exp_q.size() == 0) fail("unexpected_beat");
        else begin
          e = exp_q.pop_front();
          check("beat", 64'(got), 64'(e.v));
          if (lat_chk) check("latency", 64'(cyc - e.t), sel8 ? 64'd1 : 64'd4);
        end
      end
      if (iv && rdy) begin
        e.v = model(sel8 ? 8 : 32, x, y, s);
        e.t = cyc;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input bit sel8);
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) cycle(sel8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vec_t tbl[8];
    logic [34:0] held;
    int acc, emit0;
    bit seen;

    tbl[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

    cyc = 0; passed = 0; total = 0; n_emit = 0; lat_chk = 1'b1;
    rst = 1'b1; iv32 = 1'b0; iv8 = 1'b0; or32 = 1'b1; or8 = 1'b1;
    a32 = 32'h0; b32 = 32'h0; s32 = 1'b0; a8 = 8'h0; b8 = 8'h0; s8 = 1'b0;
    @(posedge clk); #1;
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    check("reset_state32", 64'({ov32, sum32, c32, o32, z32, ir32}), 64'({1'b0, 32'h0, 3'b000, 1'b1}));
    check("reset_state8", 64'({ov8, sum8, c8, o8, z8, ir8}), 64'({1'b0, 8'h0, 3'b000, 1'b1}));

    // directed table: one isolated beat each, expected values from the table
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].sub, 1'b1);
      seen = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
        if (ov32) begin
          seen = 1'b1;
          check($sformatf("table%0d", i), 64'({sum32, c32, o32, z32}),
                64'({tbl[i].sum, tbl[i].c, tbl[i].o, tbl[i].z}));
          check($sformatf("table%0d_lat", i), 64'(k), 64'd4);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      end
      if (!seen) fail($sformatf("table%0d_timeout", i));
    end
    drain(1'b0);

    // 100 back-to-back beats, one result per cycle at latency 4
    n_emit = 0;
    for (int i = 0; i < 100; i++)
      cycle(1'b0, 1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(1, 0)), 1'b1);
    drain(1'b0);
    check("stream_count", 64'(n_emit), 64'd100);

    // backpressure: 10 stalled cycles fill exactly 4 slots, outputs held
    lat_chk = 1'b0; n_emit = 0; acc = 0; held = 35'h0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(1, 0)), 1'b0);
      if (last_ir) acc++;
      if (i == 4) held = last_got;
    end
    check("bp_accepted", 64'(acc), 64'd4);
    check("bp_in_ready_low", 64'(last_ir), 64'd0);
    check("bp_out_valid", 64'(last_ov), 64'd1);
    check("bp_hold_stable", 64'(last_got), 64'(held));
    check("bp_head_value", 64'(held), 64'(exp_q[0].v));
    cycle(1'b0, 1'b0, 1'b1, $urandom, $urandom, 1'b1, 1'b1);
    check("full_accept_emit", 64'(last_ir), 64'd1);
    drain(1'b0);
    check("bp_count", 64'(n_emit), 64'd5);

    // random valid/ready traffic
    for (int i = 0; i < 400; i++)
      cycle(1'b0, 1'b0, 1'($urandom_range(1, 0)), $urandom, $urandom, 1'($urandom_range(1, 0)),
            1'($urandom_range(9, 0) < 7));
    drain(1'b0);

    // reset with 3 beats in flight: none may ever appear
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b1);
    check("inflight32", 64'(exp_q.size()), 64'd3);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    exp_q.delete();
    rst = 1'b0; #1;
    check("rst_flush32", 64'({ov32, ir32}), 64'({1'b0, 1'b1}));
    emit0 = n_emit;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("rst_no_output32", 64'(n_emit), 64'(emit0));

    // 8-bit, single-stage instance
    lat_chk = 1'b1; n_emit = 0;
    for (int i = 0; i < 60; i++)
      cycle(1'b1, 1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(1, 0)), 1'b1);
    drain(1'b1);
    check("stream_count8", 64'(n_emit), 64'd60);
    lat_chk = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
    check("inflight8", 64'(exp_q.size()), 64'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    exp_q.delete();
    rst = 1'b0; #1;
    check("rst_flush8", 64'({ov8, ir8}), 64'({1'b0, 1'b1}));
    emit0 = n_emit;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("rst_no_output8", 64'(n_emit), 64'(emit0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
Parametrised, pipelined two's-complement adder/subtractor. It is the successor to the single-cycle 32-bit combinational adder in the CPU datapath. It splits the WIDTH-bit carry chain into STAGES registered chunks and uses a valid/ready handshake on both sides, so it can sit in the EX stage of the pipelined CPU or feed a multi-cycle unit. It also produces the carry, signed-overflow and zero flags for branch and exception logic.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be divisible by STAGES.
- STAGES, 4, number of pipeline register stages. Range 1..WIDTH. Latency equals STAGES.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  unit accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0: A+B; 1: A-B
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result this cycle
- sum  out  WIDTH  result, modulo 2^WIDTH
- carry_out  out  1  final carry (for sub: 1 = no borrow)
- overflow  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset: all stage valid bits clear. out_valid=0, sum=0, carry_out=0, overflow=0, zero=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded. No output is produced for them.
- Chunk width: C = WIDTH/STAGES.
- Operand preparation:
  - Effective B = sub ? ~b : b.
  - Carry-in = sub.
- Stage i (0..STAGES-1):
  - Adds chunk i of A and effective B plus the carry from stage i-1 (stage 0 uses the carry-in).
  - Registers the partial sum bits [i*C +: C] and the carry.
  - Forwards the unconsumed upper operand chunks and the sign bits of A and effective B.
- Flags are computed from the final-stage registers:
  - carry_out = carry out of the MSB.
  - overflow = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]).
  - zero = ~|sum.
  - All flags are registered together with sum and are valid exactly when out_valid=1.
- Handshake:
  - A beat transfers on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
  - Per-stage advance: stage i loads when (!v[i] || adv[i+1]). adv for the last stage = out_ready.
  - in_ready = !v[0] || adv[1] (stage-0 load condition). This is a pure bubble-collapsing elastic pipeline.
  - in_ready must not depend combinationally on in_valid.
- Latency and throughput:
  - With out_ready held at 1, a beat accepted at cycle t appears with out_valid=1 at cycle t+STAGES.
  - Throughput is 1 beat/cycle.
- Backpressure: out_ready=0 holds sum and flags stable and out_valid=1. Upstream stages keep filling until all STAGES slots are full, then in_ready=0. No beat is lost or duplicated; order is preserved.
- Simultaneous accept and emit when full: if out_ready=1 and in_valid=1 in the same cycle, the pipeline shifts and accepts a new beat. in_ready=1 in that cycle.
- Width rules:
  - No sign or zero extension; everything is modulo 2^WIDTH.
  - a=0, b=0, sub=1 gives sum=0, carry_out=1, zero=1.
- STAGES=1: behaves as a registered adder with latency 1.

Decomposition:
- Shared package / header: op-mode constants ADD=1'b0, SUB=1'b1, and the helper for chunk width (WIDTH/STAGES).
- Sub-module adder_pipe_stage: parametrised by C. Holds one chunk adder, its carry register and the valid/advance logic.
- adder_pipe generates STAGES instances and the final flag logic.

Test Plan:
- Single add, WIDTH=32, STAGES=4: a=0x0000FFFF, b=0x00000001, sub=0 → after 4 cycles sum=0x00010000, carry_out=0, overflow=0, zero=0.
- Signed overflow and carry: a=0x7FFFFFFF, b=1, sub=0 → sum=0x80000000, overflow=1. a=0xFFFFFFFF, b=1 → sum=0, carry_out=1, zero=1, overflow=0.
- Subtract: a=5, b=7, sub=1 → sum=0xFFFFFFFE, carry_out=0 (borrow), overflow=0. a=0x80000000, b=1, sub=1 → sum=0x7FFFFFFF, overflow=1.
- Streaming: 100 back-to-back random beats with out_ready=1 → one result per cycle, in order, each matching the reference model, first result at cycle 4.
- Backpressure:
  - Hold out_ready=0 for 10 cycles with in_valid=1 → exactly 4 beats accepted, then in_ready=0, outputs stable.
  - Release out_ready → all beats emerge in order with no loss.
- Reset mid-stream: assert rst with 3 beats in flight → next cycle out_valid=0, in_ready=1, none of the 3 results ever appear. Repeat with STAGES=1 and WIDTH=8.
